vmode_lock_ctrl: RTL and testbench

VMODE_LOCK_CTRL -- requirements
Module: vmode_lock_ctrl

---
 rtl/vmode_pkg.sv | 29 ++
 rtl/vmode_stablecheck.sv | 50 +++++
 rtl/vmode_lock_ctrl.sv | 104 ++++++++++
 tb/tb_vmode_lock_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vmode_pkg.sv
// Shared definitions for the video-mode lock controller: state encoding,
// 16-bit field offsets within a 64-bit mode word, and the default loss timeout.
package vmode_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_COMMIT = 2'd1,
    ST_LOCKED = 2'd2,
    ST_DRAIN  = 2'd3
  } vmode_state_e;

  // Field offsets within one 64-bit mode word ({active, sstart, ssend, total}).
  localparam int ACTIVE_HI = 63;
  localparam int ACTIVE_LO = 48;
  localparam int SSTART_HI = 47;
  localparam int SSTART_LO = 32;
  localparam int SSEND_HI  = 31;
  localparam int SSEND_LO  = 16;
  localparam int TOTAL_HI  = 15;
  localparam int TOTAL_LO  = 0;

  localparam logic [25:0] TIMEOUT_DEFAULT = 26'd3_000_000;

  // Active pixel/line count of a mode word; zero marks "no signal".
  function automatic logic [15:0] mode_active(input logic [63:0] m);
    return m[ACTIVE_HI:ACTIVE_LO];
  endfunction

endpackage

// File: rtl/vmode_stablecheck.sv
// Sample store, exact 128-bit compare and saturating stable-frame counter.
// Raises o_lock_hit on the strobe that completes STABLE_FRAMES identical frames.
module vmode_stablecheck
  import vmode_pkg::*;
#(
  parameter int STABLE_FRAMES = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_search,
  input  logic         i_enable,
  input  logic         i_stb,
  input  logic         i_tmo,
  input  logic         i_clear,
  input  logic [127:0] i_sample,
  output logic         o_lock_hit
);

  localparam logic [4:0] LOCK_AT = 5'(STABLE_FRAMES - 1);

  logic [127:0] stored;
  logic [3:0]   stable_cnt;
  logic [3:0]   cnt_inc;
  logic         same;

  assign same = (i_sample == stored)
             && (mode_active(i_sample[127:64]) != 16'd0)
             && (mode_active(i_sample[63:0]) != 16'd0);

  assign cnt_inc = (stable_cnt == 4'hF) ? stable_cnt : stable_cnt + 4'd1;

  // Lock when this matching strobe brings the count up to STABLE_FRAMES-1.
  assign o_lock_hit = i_search && i_enable && i_stb && same
                   && (({1'b0, stable_cnt} + 5'd1) >= LOCK_AT);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      stored     <= '0;
      stable_cnt <= '0;
    end else if (i_search) begin
      if (i_stb) begin
        stored     <= i_sample;
        stable_cnt <= (i_enable && same) ? cnt_inc : 4'd0;
      end else if (!i_enable || i_tmo) begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/vmode_lock_ctrl.sv
// Video-mode lock FSM: search for a stable mode, commit it to the capture DMA,
// hold lock, drain on mode change. Optional signal-loss timeout: VMODE_TIMEOUT_EN.
module vmode_lock_ctrl
  import vmode_pkg::*;
#(
  parameter int          STABLE_FRAMES  = 4,
  parameter logic [25:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_frame_stb,
  input  logic [63:0] i_hmode,
  input  logic [63:0] i_vmode,
  output logic [63:0] o_hmode,
  output logic [63:0] o_vmode,
  output logic        o_cfg_valid,
  input  logic        i_cfg_ready,
  output logic        o_capture_en,
  input  logic        i_dma_busy,
  output logic        o_locked,
  output logic        o_int,
  output logic [1:0]  o_state
);

  vmode_state_e state;
  logic         lock_hit;
  logic         drain_done;
  logic         tmo;
  logic         mode_changed;

  assign o_state      = state;
  assign drain_done   = (state == ST_DRAIN) && !i_dma_busy;
  assign mode_changed = i_frame_stb && ({i_hmode, i_vmode} != {o_hmode, o_vmode});

`ifdef VMODE_TIMEOUT_EN
  logic [25:0] tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_frame_stb)
      tmo_cnt <= '0;
    else if (tmo_cnt != '1)
      tmo_cnt <= tmo_cnt + 26'd1;
  end

  assign tmo = (tmo_cnt >= TIMEOUT_CYCLES);
`else
  // No counter in this build; the parameter is kept so both builds share one interface.
  assign tmo = 1'b0 & (TIMEOUT_CYCLES == '0);
`endif

  vmode_stablecheck #(
    .STABLE_FRAMES(STABLE_FRAMES)
  ) u_stablecheck (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_search   (state == ST_SEARCH),
    .i_enable   (i_enable),
    .i_stb      (i_frame_stb),
    .i_tmo      (tmo),
    .i_clear    (drain_done),
    .i_sample   ({i_hmode, i_vmode}),
    .o_lock_hit (lock_hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_SEARCH;
      o_hmode      <= '0;
      o_vmode      <= '0;
      o_cfg_valid  <= 1'b0;
      o_capture_en <= 1'b0;
      o_locked     <= 1'b0;
      o_int        <= 1'b0;
    end else begin
      o_int <= 1'b0;
      case (state)
        ST_SEARCH: if (lock_hit) begin
          o_hmode     <= i_hmode;
          o_vmode     <= i_vmode;
          o_cfg_valid <= 1'b1;
          state       <= ST_COMMIT;
        end
        // Strobes are ignored here; the committed mode stays frozen until the handshake.
        ST_COMMIT: if (i_cfg_ready) begin
          o_cfg_valid  <= 1'b0;
          o_capture_en <= 1'b1;
          o_locked     <= 1'b1;
          o_int        <= 1'b1;
          state        <= ST_LOCKED;
        end
        ST_LOCKED: if (!i_enable || tmo || mode_changed) begin
          o_capture_en <= 1'b0;
          o_locked     <= 1'b0;
          o_int        <= 1'b1;
          state        <= ST_DRAIN;
        end
        ST_DRAIN: if (!i_dma_busy) state <= ST_SEARCH;
        default: state <= ST_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vmode_lock_ctrl.sv
// Directed bench for vmode_lock_ctrl; expected values are hand-computed constants.
module tb_vmode_lock_ctrl;

  localparam logic [63:0] H1080 = {16'd1920, 16'd2008, 16'd2052, 16'd2200};
  localparam logic [63:0] V1080 = {16'd1080, 16'd1084, 16'd1089, 16'd1125};
  localparam logic [63:0] V1079 = {16'd1079, 16'd1084, 16'd1089, 16'd1125};
  localparam logic [63:0] V1126 = {16'd1080, 16'd1084, 16'd1089, 16'd1126};

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_frame_stb, i_cfg_ready, i_dma_busy;
  logic [63:0] i_hmode, i_vmode, o_hmode, o_vmode;
  logic        o_cfg_valid, o_capture_en, o_locked, o_int;
  logic [1:0]  o_state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  vmode_lock_ctrl #(.STABLE_FRAMES(4), .TIMEOUT_CYCLES(26'd100)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_frame_stb(i_frame_stb),
    .i_hmode(i_hmode), .i_vmode(i_vmode), .o_hmode(o_hmode), .o_vmode(o_vmode),
    .o_cfg_valid(o_cfg_valid), .i_cfg_ready(i_cfg_ready), .o_capture_en(o_capture_en),
    .i_dma_busy(i_dma_busy), .o_locked(o_locked), .o_int(o_int), .o_state(o_state)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic strobe(input logic [63:0] h, input logic [63:0] v);
    i_frame_stb = 1'b1; i_hmode = h; i_vmode = v;
    tick();
    i_frame_stb = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 128'(o_state), 128'd0);
    chk({tag, "_outs"}, 128'({o_cfg_valid, o_capture_en, o_locked, o_int}), 128'd0);
    chk({tag, "_mode"}, {o_hmode, o_vmode}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k;
    logic held;
    i_reset = 1'b1; i_enable = 1'b1; i_frame_stb = 1'b0; i_cfg_ready = 1'b1;
    i_dma_busy = 1'b0; i_hmode = '0; i_vmode = '0;
    tick(); tick();
    chk_all_zero("reset");
    i_reset = 1'b0;
    tick();

    // 1080p lock: 4 identical strobes, ready already high.
    for (int i = 0; i < 3; i++) strobe(H1080, V1080);
    chk("pre_lock_state", 128'(o_state), 128'd0);
    strobe(H1080, V1080);
    chk("commit_state", 128'(o_state), 128'd1);
    chk("commit_valid", 128'(o_cfg_valid), 128'd1);
    chk("commit_mode", {o_hmode, o_vmode}, {H1080, V1080});
    tick();
    chk("locked_state", 128'(o_state), 128'd2);
    chk("locked_outs", 128'({o_cfg_valid, o_capture_en, o_locked, o_int}), 128'b0111);
    tick();
    chk("int_one_pulse", 128'(o_int), 128'd0);

    // Mode change in LOCKED with DMA busy: 10 cycles of DRAIN.
    i_dma_busy = 1'b1;
    strobe(H1080, V1126);
    chk("drain_state", 128'(o_state), 128'd3);
    chk("drain_outs", 128'({o_capture_en, o_locked, o_int}), 128'b001);
    tick();
    chk("drain_int_clear", 128'(o_int), 128'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("drain_held_10", 128'(o_state), 128'd3);
    i_dma_busy = 1'b0;
    tick();
    chk("drain_exit", 128'(o_state), 128'd0);
    chk("drain_mode_kept", {o_hmode, o_vmode}, {H1080, V1080});

    // Glitch in the middle of a run restarts the count.
    i_cfg_ready = 1'b0;
    for (int i = 0; i < 3; i++) strobe(H1080, V1080);
    strobe(H1080, V1079);
    for (int i = 0; i < 3; i++) strobe(H1080, V1080);
    chk("glitch_no_lock", 128'(o_state), 128'd0);
    strobe(H1080, V1080);
    chk("glitch_lock", 128'(o_state), 128'd1);

    // COMMIT stalled for 50 cycles while inputs keep changing.
    held = 1'b1;
    for (int i = 0; i < 50; i++) begin
      strobe(H1080, {16'd1080, 16'd1084, 16'd1089, 16'(1200 + i)});
      if (o_cfg_valid !== 1'b1 || o_state !== 2'd1 || o_vmode !== V1080) held = 1'b0;
    end
    chk("commit_held_50", 128'(held), 128'd1);
    i_cfg_ready = 1'b1;
    strobe(H1080, V1126);
    chk("hs_with_stb_state", 128'(o_state), 128'd2);
    chk("hs_with_stb_locked", 128'(o_locked), 128'd1);

    // Strobes stop in LOCKED: timeout drains 101 cycles after the last strobe.
    first_k = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (first_k == 0 && o_state == 2'd3) first_k = k;
    end
`ifdef VMODE_TIMEOUT_EN
    chk("tmo_drain_cycle", 128'(first_k), 128'd101);
    tick();
    chk("tmo_back_search", 128'(o_state), 128'd0);
    for (int i = 0; i < 4; i++) strobe(H1080, V1080);
    tick();
`else
    chk("no_tmo_drain", 128'(first_k), 128'd0);
`endif
    chk("pre_reset_locked", 128'(o_state), 128'd2);

    // Reset in LOCKED: everything to zero, no interrupt.
    i_reset = 1'b1;
    tick();
    chk_all_zero("lock_reset");
    i_reset = 1'b0;
    tick();
    chk("post_reset_int", 128'(o_int), 128'd0);

    // Disabled capture holds the count at zero and blocks COMMIT.
    i_enable = 1'b0;
    for (int i = 0; i < 5; i++) strobe(H1080, V1080);
    chk("disabled_no_lock", 128'(o_state), 128'd0);
    i_enable = 1'b1;
    for (int i = 0; i < 2; i++) strobe(H1080, V1080);
    chk("reenable_no_lock", 128'(o_state), 128'd0);
    i_hmode = 64'd0; i_vmode = 64'd0;
    for (int i = 0; i < 5; i++) strobe(64'd0, 64'd0);
    chk("zero_mode_no_lock", 128'(o_state), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
